// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a self-timed serialiser.
// Frames go out back-to-back with no idle gap while the FIFO has data.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_AW      = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               wr_en_i,
   input  logic [7:0]         wr_data_i,
   output logic               full_o,
   output logic               empty_o,
   output logic [FIFO_AW:0]   level_o,
   output logic               overflow_o,
   output logic               tx_o,
   output logic               busy_o,
   output logic               tx_done_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int BW    = $clog2(CLKS_PER_BIT);
   localparam logic [FIFO_AW:0] DEPTH_L   = (FIFO_AW + 1)'(DEPTH);
   localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // FIFO storage and bookkeeping
   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wptr_q, rptr_q;
   logic [FIFO_AW:0]   level_q, level_d;
   logic               full_q, empty_q, ovf_q;
   logic               push, pop;

   // Serialiser
   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          baud_last;
   logic          load;

   // Push is gated by the registered full flag, so a same-cycle pop cannot
   // make room for a write that arrives while full.
   assign push = wr_en_i && !full_q;
   assign pop  = load;

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         level_q <= level_d;
         full_q  <= (level_d == DEPTH_L);
         empty_q <= (level_d == '0);
         if (wr_en_i && full_q) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && push) mem_q[wptr_q] <= wr_data_i;
   end

   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign level_o    = level_q;
   assign overflow_o = ovf_q;

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign baud_last = (baud_q == BAUD_LAST);

   // FSM next state; the baud counter restarts on every state entry
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!empty_q) begin
               load    = 1'b1;
               shift_d = mem_q[rptr_q];
               state_d = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (!empty_q) begin
                  load    = 1'b1;
                  shift_d = mem_q[rptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs; tx is registered from the next state so the line never glitches
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign tx_o      = tx_q;
   assign busy_o    = (state_q != IDLE);
   assign tx_done_o = (state_q == STOP) && baud_last;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line monitor decodes frames on DUT A and
// checks them against a scoreboard; DUT B covers the minimum bit period.
module tb_uart_tx_fifo;
   localparam int CPB   = 4;
   localparam int AW    = 4;
   localparam int CPB_B = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic full, empty, ovf, tx, busy, done;
   logic [AW:0] level;

   logic wr_en_b = 1'b0;
   logic [7:0] wr_data_b = '0;
   logic full_b, empty_b, ovf_b, tx_b, busy_b, done_b;
   logic [AW:0] level_b;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut_a (
      .clk_i(clk), .reset_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
      .full_o(full), .empty_o(empty), .level_o(level), .overflow_o(ovf),
      .tx_o(tx), .busy_o(busy), .tx_done_o(done));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .FIFO_AW(AW)) dut_b (
      .clk_i(clk), .reset_i(rst), .wr_en_i(wr_en_b), .wr_data_i(wr_data_b),
      .full_o(full_b), .empty_o(empty_b), .level_o(level_b), .overflow_o(ovf_b),
      .tx_o(tx_b), .busy_o(busy_b), .tx_done_o(done_b));

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   logic [7:0] sb[$];
   int done_cyc[$];
   int cyc = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line monitor for DUT A
   logic m_act = 1'b0;
   logic m_ok;
   logic stray = 1'b0;
   logic [7:0] m_byte;
   logic [7:0] exp_b;
   int m_cnt, idx, pos;

   always @(negedge clk) begin
      if (done === 1'b1) done_cyc.push_back(cyc);
      if (m_act && busy !== 1'b1) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (done === 1'b1) stray = 1'b1;
         if (!rst && tx === 1'b0) begin
            m_act  = 1'b1;
            m_cnt  = 0;
            m_byte = '0;
            m_ok   = (done === 1'b0);
         end
      end else begin
         m_cnt++;
         idx = m_cnt / CPB;
         pos = m_cnt % CPB;
         if (done !== (m_cnt == 10*CPB-1)) m_ok = 1'b0;
         if (idx == 0) begin
            if (tx !== 1'b0) m_ok = 1'b0;
         end else if (idx == 9) begin
            if (tx !== 1'b1) m_ok = 1'b0;
         end else if (pos == 0) begin
            m_byte[idx-1] = tx;
         end else if (tx !== m_byte[idx-1]) begin
            m_ok = 1'b0;
         end
         if (m_cnt == 10*CPB-1) begin
            m_act = 1'b0;
            chk("frame_sb_has_entry", 32'(sb.size() > 0), 1);
            exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            chk("frame_data", m_byte, exp_b);
            chk("frame_shape", m_ok, 1);
         end
      end
   end

   task automatic wr(input logic [7:0] d);
      wr_en = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, output int n);
      n = 0;
      while (busy === 1'b1 && n < maxc) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int n, peak;
   logic gaps_ok, quiet;
   logic [19:0] obs_tx, obs_dn, obs_bz, exp_tx;
   logic [7:0] bbyte;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_level", level, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_tx_b", tx_b, 1);

      // Single byte latency and frame length
      done_cyc.delete();
      sb.push_back(8'hA5);
      wr(8'hA5);
      chk("lat_level1", level, 1);
      chk("lat_tx_idle", tx, 1);
      chk("lat_empty0", empty, 0);
      @(negedge clk);
      chk("lat_tx_fall", tx, 0);
      chk("lat_busy", busy, 1);
      chk("lat_level0", level, 0);
      chk("lat_empty1", empty, 1);
      wait_idle(100, n);
      chk("single_busy_len", n, 40);
      chk("single_sb_drained", sb.size(), 0);
      chk("single_done_cnt", done_cyc.size(), 1);

      // Back-to-back frames
      done_cyc.delete();
      sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'h55);
      peak = 0;
      wr(8'h00); if (int'(level) > peak) peak = int'(level);
      wr(8'hFF); if (int'(level) > peak) peak = int'(level);
      wr(8'h55);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         if (int'(level) > peak) peak = int'(level);
         n++;
         @(negedge clk);
      end
      chk("b2b_idle", busy, 0);
      chk("b2b_peak", peak, 2);
      chk("b2b_done_cnt", done_cyc.size(), 3);
      chk("b2b_gap1", done_cyc[1] - done_cyc[0], 40);
      chk("b2b_gap2", done_cyc[2] - done_cyc[1], 40);
      chk("b2b_empty", empty, 1);
      chk("b2b_sb_drained", sb.size(), 0);

      // Overflow while busy
      done_cyc.delete();
      for (int i = 1; i <= 17; i++) begin
         sb.push_back(8'(i));
         wr(8'(i));
      end
      chk("ovf_full", full, 1);
      chk("ovf_level16", level, 16);
      chk("ovf_not_yet", ovf, 0);
      wr(8'h12);
      chk("ovf_set", ovf, 1);
      chk("ovf_level_keep", level, 16);
      wait_idle(1000, n);
      chk("ovf_idle", busy, 0);
      chk("ovf_done_cnt", done_cyc.size(), 17);
      gaps_ok = 1'b1;
      for (int i = 1; i < done_cyc.size(); i++)
         if (done_cyc[i] - done_cyc[i-1] != 40) gaps_ok = 1'b0;
      chk("ovf_gaps", gaps_ok, 1);
      chk("ovf_sb_drained", sb.size(), 0);

      // Write while full in the last stop cycle
      rst_pulse();
      chk("pp_ovf_clr", ovf, 0);
      done_cyc.delete();
      for (int i = 0; i < 17; i++) begin
         sb.push_back(8'h20 + 8'(i));
         wr(8'h20 + 8'(i));
      end
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("pp_done_seen", done, 1);
      chk("pp_full_pre", full, 1);
      wr_en = 1'b1;
      wr_data = 8'hEE;
      @(negedge clk);
      wr_en = 1'b0;
      chk("pp_ovf", ovf, 1);
      chk("pp_level15", level, 15);
      chk("pp_full_post", full, 0);
      wait_idle(1000, n);
      chk("pp_idle", busy, 0);
      chk("pp_done_cnt", done_cyc.size(), 17);
      chk("pp_sb_drained", sb.size(), 0);

      // Reset in data bit 3 with a queue behind it; write during reset ignored
      rst_pulse();
      for (int i = 0; i < 6; i++) begin
         sb.push_back(8'h61 + 8'(i));
         wr(8'h61 + 8'(i));
      end
      repeat (13) @(negedge clk);
      done_cyc.delete();
      rst = 1'b1;
      wr_en = 1'b1;
      wr_data = 8'h77;
      @(negedge clk);
      rst = 1'b0;
      wr_en = 1'b0;
      sb.delete();
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_empty", empty, 1);
      quiet = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || level !== '0) quiet = 1'b0;
      end
      chk("mid_rst_quiet", quiet, 1);
      chk("mid_rst_no_done", done_cyc.size(), 0);

      // Minimum bit period on DUT B
      bbyte = 8'h3C;
      for (int k = 0; k < 20; k++) begin
         if (k / 2 == 0)      exp_tx[k] = 1'b0;
         else if (k / 2 == 9) exp_tx[k] = 1'b1;
         else                 exp_tx[k] = bbyte[k/2 - 1];
      end
      wr_en_b = 1'b1;
      wr_data_b = bbyte;
      @(negedge clk);
      wr_en_b = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         obs_tx[k] = tx_b;
         obs_dn[k] = done_b;
         obs_bz[k] = busy_b;
      end
      chk("min_frame_bits", obs_tx, exp_tx);
      chk("min_done_pos", obs_dn, 20'h80000);
      chk("min_busy", obs_bz, 20'hFFFFF);
      @(negedge clk);
      chk("min_end_busy", busy_b, 0);
      chk("min_end_tx", tx_b, 1);

      chk("no_stray_done", stray, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
